fetch_queue: RTL and testbench

- Instruction fetch buffer between the program counter / instruction memory and the ID stage of the pipelined MIPS core.
- Captures one {pc, instruction} pair per fetch cycle and presents entries in order to ID over a valid/ready handshake.
- Drives the PC hold request back to the PC register when full; this is the consumer end of the PC interface.
- Discards all buffered entries on a branch/jump flush.

---
 rtl/fetch_queue_pkg.sv | 24 ++
 rtl/fetch_queue_mem.sv | 34 +++
 rtl/fetch_queue.sv | 124 ++++++++++++
 tb/tb_fetch_queue.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Core-wide fetch definitions shared by the PC, IF and ID stages.
//   PC_W / INSTR_W : address and instruction word widths
//   PC_INCR        : sequential PC step (one 32-bit word)
//   NOP_INSTR      : encoding presented when no instruction is available
//   fetch_entry_t  : one fetched {pc, instr} pair as carried from IF to ID
package fetch_queue_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [PC_W-1:0]    PC_INCR   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Address of the sequentially next instruction; wraps modulo 2^32.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_INCR;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x {pc, instr} register array.
// One synchronous write port, one asynchronous read port. The data array
// has no reset; validity is tracked by the controller in fetch_queue.
//   clk_i     : clock, rising edge
//   we_i      : write enable
//   waddr_i   : write slot
//   wdata_i   : entry to store
//   raddr_i   : read slot
//   rdata_o   : entry at raddr_i (combinational)
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  fetch_entry_t  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fetch_entry_t  rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch buffer between the PC / instruction memory and ID.
// Captures one {pc, instr} pair per fetch cycle, presents entries in order
// to ID over a valid/ready handshake, holds the PC while full and discards
// everything on a branch/jump flush.
//   clk_i, rst_i     : clock and synchronous active-high reset
//   start_i          : core run enable, gates enqueue
//   fetch_valid_i    : pc_i / instr_i carry a fetched instruction
//   pc_i, instr_i    : fetched address and instruction word
//   flush_i          : redirect, empties the queue
//   pc_stall_o       : PC hold request (queue full)
//   id_valid_o       : head entry valid
//   id_ready_i       : ID accepts the head entry
//   id_pc_o          : head PC (0 when empty)
//   id_pc4_o         : head PC + 4 (4 when empty)
//   id_instr_o       : head instruction (nop when empty)
//   overflow_o       : sticky, enqueue attempted while full
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               fetch_valid_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               flush_i,
  output logic               pc_stall_o,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [PC_W-1:0]    id_pc_o,
  output logic [PC_W-1:0]    id_pc4_o,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic               overflow_o
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW:0]   count_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic          overflow_q;

  logic          full;
  logic          not_empty;
  logic          enq_req;
  logic          enq;
  logic          deq;
  logic          mem_we;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head_entry;

  assign full      = (count_q == CNT_FULL);
  assign not_empty = (count_q != '0);

  // The slot freed by a dequeue in a full cycle is not reused until the
  // next cycle, so full alone blocks the enqueue.
  assign enq_req = start_i & fetch_valid_i;
  assign enq     = enq_req & ~full;
  assign deq     = not_empty & id_ready_i;

  // A flushed enqueue never reaches the array.
  assign mem_we         = enq & ~flush_i;
  assign wr_entry.pc    = pc_i;
  assign wr_entry.instr = instr_i;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (enq_req && full) begin
        overflow_q <= 1'b1;
      end
      if (flush_i) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        // DEPTH is a power of two, so AW-bit pointers wrap on their own.
        if (enq) begin
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
        end
        if (deq) begin
          rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
        if (enq && !deq) begin
          count_q <= count_q + CNT_ONE;
        end else if (!enq && deq) begin
          count_q <= count_q - CNT_ONE;
        end
      end
    end
  end

  // Registered-state only: no path from fetch_valid_i or id_ready_i.
  assign pc_stall_o = full;
  assign id_valid_o = not_empty;
  assign overflow_o = overflow_q;

  // Empty queue presents a nop at PC 0 so ID sees harmless data.
  assign id_pc_o    = not_empty ? head_entry.pc    : '0;
  assign id_instr_o = not_empty ? head_entry.instr : NOP_INSTR;
  assign id_pc4_o   = pc_next(id_pc_o);

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, fetch_valid_i, flush_i, id_ready_i;
  logic [31:0] pc_i, instr_i;
  logic        pc_stall_o, id_valid_o, overflow_o;
  logic [31:0] id_pc_o, id_pc4_o, id_instr_o;

  int nerr = 0;
  int nchk = 0;

  // Reference model: an ordered list of {pc, instr} entries plus the sticky flag.
  logic [63:0] mq[$];
  bit          m_ovf;

  always #5 clk_i = ~clk_i;

  fetch_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .fetch_valid_i (fetch_valid_i),
    .pc_i          (pc_i),
    .instr_i       (instr_i),
    .flush_i       (flush_i),
    .pc_stall_o    (pc_stall_o),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_pc_o       (id_pc_o),
    .id_pc4_o      (id_pc4_o),
    .id_instr_o    (id_instr_o),
    .overflow_o    (overflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] epc, einstr;
    epc    = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
    einstr = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
    chk("id_valid", {31'b0, id_valid_o}, {31'b0, mq.size() != 0});
    chk("pc_stall", {31'b0, pc_stall_o}, {31'b0, mq.size() == DEPTH});
    chk("overflow", {31'b0, overflow_o}, {31'b0, m_ovf});
    chk("id_pc",    id_pc_o,    epc);
    chk("id_pc4",   id_pc4_o,   epc + 32'd4);
    chk("id_instr", id_instr_o, einstr);
  endtask

  // Called at a falling edge: drive inputs, advance the model across the
  // coming rising edge, then compare at the next falling edge.
  task automatic cycle(input bit rst, input bit start, input bit fv,
                       input logic [31:0] pc, input logic [31:0] instr,
                       input bit flush, input bit ready);
    bit full, dq;
    rst_i = rst; start_i = start; fetch_valid_i = fv; pc_i = pc;
    instr_i = instr; flush_i = flush; id_ready_i = ready;
    if (rst) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      full = (mq.size() == DEPTH);
      dq   = (mq.size() != 0) && ready;
      if (start && fv && full) m_ovf = 1;
      if (flush) mq.delete();
      else begin
        if (dq) void'(mq.pop_front());
        if (start && fv && !full) mq.push_back({pc, instr});
      end
    end
    @(negedge clk_i);
    check_all();
  endtask

  task automatic idle(input bit ready);
    cycle(0, 1, 0, 32'h0, 32'h0, 0, ready);
  endtask

  task automatic enq(input logic [31:0] pc, input logic [31:0] instr, input bit ready);
    cycle(0, 1, 1, pc, instr, 0, ready);
  endtask

  initial begin
    m_ovf = 0;
    cycle(1, 0, 0, 32'h0, 32'h0, 0, 0);
    cycle(1, 1, 1, 32'h1234, 32'h5678, 1, 1);
    chk("reset_pc4", id_pc4_o, 32'd4);

    // Fill with ID stalled, then one more fetch while full.
    for (int i = 0; i < 4; i++) enq(32'(i * 4), 32'h2008_0001 + 32'(i), 0);
    chk("fill_stall", {31'b0, pc_stall_o}, 32'd1);
    enq(32'h10, 32'h2008_0005, 0);
    chk("ovf_set", {31'b0, overflow_o}, 32'd1);
    chk("ovf_head", id_pc_o, 32'h0);

    // Drain in order.
    for (int i = 0; i < 4; i++) idle(1);
    chk("drain_empty_instr", id_instr_o, 32'h0);

    // Steady enq+deq at two entries across pointer wrap.
    enq(32'h100, 32'hA000_0000, 0);
    enq(32'h104, 32'hA000_0001, 0);
    for (int i = 0; i < 6; i++) enq(32'h108 + 32'(i * 4), 32'hA000_0002 + 32'(i), 1);
    chk("steady_pc", id_pc_o, 32'h118);
    for (int i = 0; i < 2; i++) idle(1);

    // Flush at three entries with a concurrent enqueue.
    for (int i = 0; i < 3; i++) enq(32'h20 + 32'(i * 4), 32'hB000_0000 + 32'(i), 0);
    cycle(0, 1, 1, 32'h40, 32'hB000_0040, 1, 1);
    chk("flush_valid", {31'b0, id_valid_o}, 32'd0);
    enq(32'h80, 32'hB000_0080, 0);
    chk("after_flush_head", id_pc_o, 32'h80);
    idle(1);

    // PC + 4 wraps modulo 2^32.
    enq(32'hFFFF_FFFC, 32'hC000_0000, 0);
    chk("pc4_wrap", id_pc4_o, 32'h0);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 3) != 0, $urandom(), $urandom(),
            $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    end

    // Reset while full with ID ready; then start low ignores fetches.
    for (int i = 0; i < 5; i++) enq(32'h200 + 32'(i * 4), 32'hD000_0000 + 32'(i), 0);
    chk("prereset_ovf", {31'b0, overflow_o}, 32'd1);
    cycle(1, 1, 1, 32'h300, 32'hD000_0300, 0, 1);
    chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
    chk("rst_stall", {31'b0, pc_stall_o}, 32'd0);
    chk("rst_ovf",   {31'b0, overflow_o}, 32'd0);
    cycle(0, 0, 1, 32'h304, 32'hD000_0304, 0, 0);
    cycle(0, 0, 1, 32'h308, 32'hD000_0308, 0, 0);
    chk("nostart_valid", {31'b0, id_valid_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
